// File: rtl/stepper_segment_sequencer.sv
// Segment sequencer: the CPU stages {count, period, dir} through byte registers and
// pushes them into a small FIFO; segments are replayed as step_x pulse trains on one axis.
module stepper_segment_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_W    = 4,
  parameter int DIR_SETUP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_data_in,
  output logic [7:0] cpu_data_out,
  output logic       dir_x,
  output logic       step_x
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] PE_MIN  = 16'(PULSE_W + 1);
  localparam logic [15:0] PW_LAST = 16'(PULSE_W - 1);
  localparam logic [15:0] DS_LAST = 16'(DIR_SETUP - 1);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, DSETUP, PULSE, WAIT} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   phase_reg, phase_next;
  logic [15:0]   count_stage_reg, period_stage_reg;
  logic [15:0]   remaining_reg, pe_reg;
  logic          dir_reg, step_reg, overflow_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [32:0]   fifo_mem [FIFO_DEPTH];
  logic [7:0]    rd_data;

  logic push_req, cmd_wr, abort, clr_ovf, full, empty, push_ok, pop, period_done;
  logic [32:0] head;
  logic [15:0] head_count, head_period, head_pe;
  logic        head_dir;

  assign push_req = wr && (cpu_addr == 8'h04);
  assign cmd_wr   = wr && (cpu_addr == 8'h06);
  assign abort    = cmd_wr && cpu_data_in[0];
  assign clr_ovf  = cmd_wr && cpu_data_in[1];
  assign full     = (level_reg == LVL_FULL);
  assign empty    = (level_reg == '0);
  // A full FIFO drops the push even when LOAD frees a slot in the same cycle.
  assign push_ok  = push_req && !full && !abort;
  assign pop      = (state_reg == LOAD) && !abort;

  assign head        = fifo_mem[rd_ptr_reg];
  assign head_count  = head[15:0];
  assign head_period = head[31:16];
  assign head_dir    = head[32];
  assign head_pe     = (head_period < PE_MIN) ? PE_MIN : head_period;
  assign period_done = (phase_reg == pe_reg - 16'd1);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    case (state_reg)
      IDLE: if (!empty) state_next = LOAD;
      LOAD: begin
        phase_next = '0;
        if (head_count == 16'd0)
          state_next = (level_reg > LVL_ONE) ? LOAD : IDLE;
        else if (head_dir != dir_reg)
          state_next = DSETUP;
        else
          state_next = PULSE;
      end
      DSETUP: begin
        if (phase_reg == DS_LAST) begin
          state_next = PULSE;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + 16'd1;
        end
      end
      PULSE: begin
        phase_next = phase_reg + 16'd1;
        if (phase_reg == PW_LAST) state_next = WAIT;
      end
      WAIT: begin
        // phase keeps counting from the first PULSE cycle so rises are exactly Pe apart
        if (period_done) begin
          phase_next = '0;
          if (remaining_reg > 16'd1) state_next = PULSE;
          else if (!empty)           state_next = LOAD;
          else                       state_next = IDLE;
        end else begin
          phase_next = phase_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      phase_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      step_reg      <= 1'b0;
      dir_reg       <= 1'b0;
      remaining_reg <= '0;
      pe_reg        <= PE_MIN;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      step_reg  <= (state_next == PULSE);
      if (abort) begin
        remaining_reg <= '0;
      end else if (state_reg == LOAD) begin
        remaining_reg <= head_count;
        pe_reg        <= head_pe;
        if (head_count != 16'd0) dir_reg <= head_dir;
      end else if (state_reg == WAIT && period_done) begin
        remaining_reg <= remaining_reg - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      overflow_reg     <= 1'b0;
      count_stage_reg  <= '0;
      period_stage_reg <= '0;
      cpu_data_out     <= 8'h00;
    end else begin
      if (abort) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        if (push_ok && !pop)      level_reg <= level_reg + LVL_ONE;
        else if (!push_ok && pop) level_reg <= level_reg - LVL_ONE;
      end
      if (push_req && full && !abort) overflow_reg <= 1'b1;
      else if (clr_ovf)               overflow_reg <= 1'b0;
      if (wr) begin
        case (cpu_addr)
          8'h00: count_stage_reg[7:0]   <= cpu_data_in;
          8'h01: count_stage_reg[15:8]  <= cpu_data_in;
          8'h02: period_stage_reg[7:0]  <= cpu_data_in;
          8'h03: period_stage_reg[15:8] <= cpu_data_in;
          default: ;
        endcase
      end
      if (rd) cpu_data_out <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= {cpu_data_in[0], period_stage_reg, count_stage_reg};
  end

  always_comb begin
    rd_data = 8'h00;
    case (cpu_addr)
      8'h00: rd_data = count_stage_reg[7:0];
      8'h01: rd_data = count_stage_reg[15:8];
      8'h02: rd_data = period_stage_reg[7:0];
      8'h03: rd_data = period_stage_reg[15:8];
      8'h05: rd_data = {1'b0, 3'(level_reg), overflow_reg, empty, full, (state_reg != IDLE)};
      8'h07: rd_data = remaining_reg[7:0];
      default: ;
    endcase
  end

  assign dir_x  = dir_reg;
  assign step_x = step_reg;

endmodule

// File: tb/tb_stepper_segment_sequencer.sv
// Directed bench for stepper_segment_sequencer: pulse timing, direction setup,
// clamp/zero-count, overflow, abort and asynchronous reset.
module tb_stepper_segment_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_data_in = 8'h00;
  logic [7:0] cpu_data_out;
  logic       dir_x, step_x;

  stepper_segment_sequencer #(.FIFO_DEPTH(4), .PULSE_W(4), .DIR_SETUP(2)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .dir_x(dir_x), .step_x(step_x)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge log, sampled just after each rising edge.
  int   rise_q[$];
  int   fall_q[$];
  int   dirchg_q[$];
  int   dir_viol = 0;
  logic prev_step = 1'b0;
  logic prev_dir = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (step_x && !prev_step) rise_q.push_back(cyc);
    if (!step_x && prev_step) fall_q.push_back(cyc);
    if (dir_x != prev_dir) begin
      dirchg_q.push_back(cyc);
      if (step_x || prev_step) dir_viol++;
    end
    prev_step = step_x;
    prev_dir  = dir_x;
  end

  int checks = 0;
  int errors = 0;
  int last_wr_cyc = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d (0x%0h)", tag, got, got);
    end
  endtask

  function automatic int rise_at(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1000;
  endfunction
  function automatic int fall_at(input int i);
    return (i < fall_q.size()) ? fall_q[i] : -1000;
  endfunction
  function automatic int dirchg_at(input int i);
    return (i < dirchg_q.size()) ? dirchg_q[i] : -1000;
  endfunction

  // All bus tasks are entered at a falling edge and return at the next one.
  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
    cpu_addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = cpu_data_out;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rise_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rise_q.size() < n) check_eq("rise_timeout", rise_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    logic [7:0] s = 8'h01;
    int k = 0;
    while (s[0] && k < budget) begin
      reg_read(8'h05, s);
      k++;
    end
    if (s[0]) check_eq("idle_timeout", int'(s[0]), 0);
  endtask

  task automatic wait_until(input int c);
    int k = 0;
    while (cyc < c && k < 1000) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    logic [7:0] d;
    int n0, f0, d0, p, r;

    repeat (3) @(negedge clk);
    check_eq("rst_step", step_x, 0);
    check_eq("rst_dir", dir_x, 0);
    check_eq("rst_data", cpu_data_out, 0);
    reset = 1'b1;
    @(negedge clk);
    reg_read(8'h05, d); check_eq("rst_status", d, 8'h04);
    reg_read(8'h00, d); check_eq("rst_count_lo", d, 8'h00);

    // Basic segment: 3 pulses, period 10, dir 0
    reg_write(8'h00, 8'd3);
    reg_write(8'h02, 8'd10);
    n0 = rise_q.size(); f0 = fall_q.size();
    reg_write(8'h04, 8'h00);
    p = last_wr_cyc;
    wait_rises(n0 + 3, 200);
    r = rise_at(n0 + 2);
    wait_until(r + 9);
    reg_read(8'h05, d); check_eq("b_status_last_wait", d, 8'h05);
    reg_read(8'h05, d); check_eq("b_status_idle", d, 8'h04);
    check_eq("b_latency", rise_at(n0) - p, 2);
    check_eq("b_period1", rise_at(n0 + 1) - rise_at(n0), 10);
    check_eq("b_period2", rise_at(n0 + 2) - rise_at(n0 + 1), 10);
    for (int i = 0; i < 3; i++) check_eq("b_width", fall_at(f0 + i) - rise_at(n0 + i), 4);
    check_eq("b_count", rise_q.size() - n0, 3);
    check_eq("b_dir", dir_x, 0);
    reg_read(8'h02, d); check_eq("b_staged_period", d, 8'd10);
    reg_read(8'h09, d); check_eq("b_unmapped_rd", d, 8'h00);
    reg_read(8'h02, d);
    reg_read(8'h04, d); check_eq("b_push_rd", d, 8'h00);

    // Direction change between two segments
    reg_write(8'h00, 8'd2);
    reg_write(8'h02, 8'd8);
    n0 = rise_q.size(); d0 = dirchg_q.size();
    reg_write(8'h04, 8'h01);
    p = last_wr_cyc;
    reg_write(8'h04, 8'h00);
    wait_rises(n0 + 4, 300);
    wait_idle(100);
    check_eq("d_latency", rise_at(n0) - p, 4);
    check_eq("d_setup_a", rise_at(n0) - dirchg_at(d0), 2);
    check_eq("d_period_a", rise_at(n0 + 1) - rise_at(n0), 8);
    check_eq("d_gap_ab", rise_at(n0 + 2) - rise_at(n0 + 1), 11);
    check_eq("d_setup_b", rise_at(n0 + 2) - dirchg_at(d0 + 1), 2);
    check_eq("d_period_b", rise_at(n0 + 3) - rise_at(n0 + 2), 8);
    check_eq("d_dir_changes", dirchg_q.size() - d0, 2);
    check_eq("d_count", rise_q.size() - n0, 4);

    // Period clamp, then a zero-count segment between two real ones
    reg_write(8'h02, 8'd1);
    n0 = rise_q.size();
    reg_write(8'h04, 8'h00);
    p = last_wr_cyc;
    reg_write(8'h00, 8'd0);
    reg_write(8'h04, 8'h00);
    reg_write(8'h00, 8'd1);
    reg_write(8'h02, 8'd6);
    reg_write(8'h04, 8'h00);
    wait_rises(n0 + 3, 200);
    wait_idle(100);
    check_eq("z_latency", rise_at(n0) - p, 2);
    check_eq("z_clamped", rise_at(n0 + 1) - rise_at(n0), 5);
    check_eq("z_gap_skip", rise_at(n0 + 2) - rise_at(n0 + 1), 7);
    check_eq("z_count", rise_q.size() - n0, 3);

    // Overflow while a segment runs, then abort mid-pulse
    reg_write(8'h00, 8'd4);
    reg_write(8'h02, 8'd20);
    n0 = rise_q.size();
    reg_write(8'h04, 8'h01);
    wait_rises(n0 + 1, 50);
    reg_read(8'h07, d); check_eq("o_remaining", d, 8'd4);
    repeat (5) reg_write(8'h04, 8'h01);
    reg_read(8'h05, d); check_eq("o_status_ovf", d, 8'h4B);
    reg_write(8'h06, 8'h02);
    reg_read(8'h05, d); check_eq("o_status_clr", d, 8'h43);
    reg_read(8'h00, d); check_eq("o_staged_count", d, 8'd4);
    reg_read(8'h02, d); check_eq("o_staged_period", d, 8'd20);
    wait_rises(n0 + 2, 100);
    check_eq("a_step_before", step_x, 1);
    reg_write(8'h06, 8'h01);
    check_eq("a_step_after", step_x, 0);
    check_eq("a_dir_held", dir_x, 1);
    reg_read(8'h05, d); check_eq("a_status", d, 8'h04);
    reg_read(8'h07, d); check_eq("a_remaining", d, 8'h00);
    repeat (100) @(negedge clk);
    check_eq("a_no_more_pulses", rise_q.size() - n0, 2);

    // Reset asserted during WAIT with a full FIFO and overflow set
    reg_write(8'h00, 8'd3);
    reg_write(8'h02, 8'd10);
    n0 = rise_q.size();
    reg_write(8'h04, 8'h01);
    wait_rises(n0 + 1, 50);
    repeat (5) reg_write(8'h04, 8'h01);
    reg_read(8'h05, d); check_eq("r_status_pre", d, 8'h4B);
    check_eq("r_step_in_wait", step_x, 0);
    #2 reset = 1'b0;
    #1;
    check_eq("r_step", step_x, 0);
    check_eq("r_dir", dir_x, 0);
    check_eq("r_data", cpu_data_out, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reg_read(8'h05, d); check_eq("r_status_post", d, 8'h04);
    reg_read(8'h00, d); check_eq("r_staged_cleared", d, 8'h00);

    check_eq("dir_toggle_while_high", dir_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
